// File: rtl/if_id_skid_reg_if.sv
// rtl/if_id_skid_reg_if.sv - IF/ID handshake and payload bundle between fetch, the IF/ID register and decode
interface if_id_skid_reg_if #(
  parameter int unsigned XLEN = 32
);
  // fetch side
  logic            IN_VALID;
  logic [XLEN-1:0] PC_IF;
  logic [XLEN-1:0] INSTRUCTION_IF;
  logic            IN_READY;
  // decode side
  logic [XLEN-1:0] PC_IFID;
  logic [XLEN-1:0] INSTRUCTION_IFID;
  logic            VALID_IFID;

  // Pipeline environment: fetch drives the offer, decode observes the slot.
  modport master (
    output IN_VALID,
    output PC_IF,
    output INSTRUCTION_IF,
    input  IN_READY,
    input  PC_IFID,
    input  INSTRUCTION_IFID,
    input  VALID_IFID
  );

  // The IF/ID register itself.
  modport slave (
    input  IN_VALID,
    input  PC_IF,
    input  INSTRUCTION_IF,
    output IN_READY,
    output PC_IFID,
    output INSTRUCTION_IFID,
    output VALID_IFID
  );
endinterface

// File: rtl/if_id_skid_reg.sv
// rtl/if_id_skid_reg.sv - IF/ID pipeline register with 1-entry skid buffer; optional perf counters via IFID_PERF_CNT_EN
module if_id_skid_reg #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] NOP_INSTR = '0,
  parameter int unsigned     CNT_W     = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             FLUSH,
  input  logic             HOLD,
  input  logic             MEM_BUSYWAIT,
  if_id_skid_reg_if.slave  bus
`ifdef IFID_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] STALL_CNT,
  output logic [CNT_W-1:0] FLUSH_CNT
`endif
);

  // EMPTY: output slot is a bubble; FULL: output valid; SKID: output and skid both valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL  = 2'b01,
    ST_SKID  = 2'b11
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] out_pc_q, out_pc_d;
  logic [XLEN-1:0] out_instr_q, out_instr_d;
  logic [XLEN-1:0] skid_pc_q, skid_pc_d;
  logic [XLEN-1:0] skid_instr_q, skid_instr_d;
  logic            in_ready_q;

  logic adv;
  logic acc;

  // decode takes the output this cycle / fetch hands over an item this cycle
  assign adv = !HOLD && !MEM_BUSYWAIT;
  assign acc = bus.IN_VALID && in_ready_q;

  assign bus.IN_READY         = in_ready_q;
  assign bus.PC_IFID          = out_pc_q;
  assign bus.INSTRUCTION_IFID = out_instr_q;
  assign bus.VALID_IFID       = (state_q != ST_EMPTY);

  // State register; reset drops all contents at once.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-contents; flush wins over every handshake outcome.
  always_comb begin
    state_d      = state_q;
    out_pc_d     = out_pc_q;
    out_instr_d  = out_instr_q;
    skid_pc_d    = skid_pc_q;
    skid_instr_d = skid_instr_q;

    if (FLUSH) begin
      state_d      = ST_EMPTY;
      out_pc_d     = '0;
      out_instr_d  = NOP_INSTR;
      skid_pc_d    = '0;
      skid_instr_d = NOP_INSTR;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          // an empty slot is filled even while decode is stalled
          if (acc) begin
            state_d     = ST_FULL;
            out_pc_d    = bus.PC_IF;
            out_instr_d = bus.INSTRUCTION_IF;
          end
        end
        ST_FULL: begin
          if (adv && acc) begin
            out_pc_d    = bus.PC_IF;
            out_instr_d = bus.INSTRUCTION_IF;
          end else if (adv) begin
            state_d     = ST_EMPTY;
            out_pc_d    = '0;
            out_instr_d = NOP_INSTR;
          end else if (acc) begin
            // IN_READY was already high, so the item must be parked
            state_d      = ST_SKID;
            skid_pc_d    = bus.PC_IF;
            skid_instr_d = bus.INSTRUCTION_IF;
          end
        end
        ST_SKID: begin
          if (adv) begin
            state_d      = ST_FULL;
            out_pc_d     = skid_pc_q;
            out_instr_d  = skid_instr_q;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
          end
        end
        default: begin
          state_d     = ST_EMPTY;
          out_pc_d    = '0;
          out_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  // Output slot and skid entry storage.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      out_pc_q     <= '0;
      out_instr_q  <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
    end else begin
      out_pc_q     <= out_pc_d;
      out_instr_q  <= out_instr_d;
      skid_pc_q    <= skid_pc_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // IN_READY is a flop so decode stalls never reach fetch combinationally.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (state_d != ST_SKID);
    end
  end

`ifdef IFID_PERF_CNT_EN
  logic stall_inc;
  logic flush_inc;

  assign stall_inc = bus.VALID_IFID && !adv && !FLUSH;
  assign flush_inc = FLUSH && (state_q != ST_EMPTY);

  // Saturating stall and flush counters, cleared only by reset.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      STALL_CNT <= '0;
      FLUSH_CNT <= '0;
    end else begin
      if (stall_inc && (STALL_CNT != {CNT_W{1'b1}})) begin
        STALL_CNT <= STALL_CNT + 1'b1;
      end
      if (flush_inc && (FLUSH_CNT != {CNT_W{1'b1}})) begin
        FLUSH_CNT <= FLUSH_CNT + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// tb/tb_if_id_skid_reg.sv - directed self-checking bench for if_id_skid_reg
module tb_if_id_skid_reg;
  localparam int unsigned     XLEN  = 32;
  localparam logic [31:0]     NOP   = 32'h0000_0013;
  localparam int unsigned     CNT_W = 2;

  logic CLK;
  logic RESET;
  logic FLUSH;
  logic HOLD;
  logic MEM_BUSYWAIT;

  int checks;
  int failures;

  if_id_skid_reg_if #(.XLEN(XLEN)) bus ();

`ifdef IFID_PERF_CNT_EN
  logic [CNT_W-1:0] STALL_CNT;
  logic [CNT_W-1:0] FLUSH_CNT;
`endif

  if_id_skid_reg #(
    .XLEN(XLEN),
    .NOP_INSTR(NOP),
    .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK),
    .RESET(RESET),
    .FLUSH(FLUSH),
    .HOLD(HOLD),
    .MEM_BUSYWAIT(MEM_BUSYWAIT),
    .bus(bus.slave)
`ifdef IFID_PERF_CNT_EN
    ,
    .STALL_CNT(STALL_CNT),
    .FLUSH_CNT(FLUSH_CNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc);
    bus.IN_VALID       = v;
    bus.PC_IF          = pc;
    bus.INSTRUCTION_IF = instr_of(pc);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc,
                         input logic [31:0] ins, input logic rdy);
    chk({tag, ".valid"}, {31'd0, bus.VALID_IFID}, {31'd0, v});
    chk({tag, ".pc"}, bus.PC_IFID, pc);
    chk({tag, ".instr"}, bus.INSTRUCTION_IFID, ins);
    chk({tag, ".ready"}, {31'd0, bus.IN_READY}, {31'd0, rdy});
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    RESET        = 1'b1;
    FLUSH        = 1'b0;
    HOLD         = 1'b0;
    MEM_BUSYWAIT = 1'b0;
    offer(1'b0, 32'h0);

    step();
    step();
    chk_out("reset", 1'b0, 32'h0, NOP, 1'b1);
`ifdef IFID_PERF_CNT_EN
    chk("reset.stall_cnt", {30'd0, STALL_CNT}, 32'd0);
    chk("reset.flush_cnt", {30'd0, FLUSH_CNT}, 32'd0);
`endif
    RESET = 1'b0;

    // back-to-back stream
    offer(1'b1, 32'h0);
    step();
    chk_out("stream0", 1'b1, 32'h0, instr_of(32'h0), 1'b1);
    offer(1'b1, 32'h4);
    step();
    chk_out("stream4", 1'b1, 32'h4, instr_of(32'h4), 1'b1);
    offer(1'b1, 32'h8);
    step();
    chk_out("stream8", 1'b1, 32'h8, instr_of(32'h8), 1'b1);
    offer(1'b1, 32'h10);
    step();
    chk_out("stream10", 1'b1, 32'h10, instr_of(32'h10), 1'b1);

    // two-cycle hold: 0x14 parks in skid, 0x18 is refused
    HOLD = 1'b1;
    offer(1'b1, 32'h14);
    step();
    chk_out("hold1", 1'b1, 32'h10, instr_of(32'h10), 1'b0);
    offer(1'b1, 32'h18);
    step();
    chk_out("hold2", 1'b1, 32'h10, instr_of(32'h10), 1'b0);
    HOLD = 1'b0;
    step();
    chk_out("unhold_skid", 1'b1, 32'h14, instr_of(32'h14), 1'b1);
    step();
    chk_out("unhold_next", 1'b1, 32'h18, instr_of(32'h18), 1'b1);

    // memory busy also stalls the slot
    MEM_BUSYWAIT = 1'b1;
    offer(1'b0, 32'h1C);
    step();
    chk_out("membusy", 1'b1, 32'h18, instr_of(32'h18), 1'b1);
    MEM_BUSYWAIT = 1'b0;

    // imem bubble then load while held
    step();
    chk_out("bubble", 1'b0, 32'h0, NOP, 1'b1);
    HOLD = 1'b1;
    offer(1'b1, 32'h1C);
    step();
    chk_out("collapse", 1'b1, 32'h1C, instr_of(32'h1C), 1'b1);

    // fill skid then flush with a live offer
    offer(1'b1, 32'h20);
    step();
    chk_out("skid_fill", 1'b1, 32'h1C, instr_of(32'h1C), 1'b0);
`ifdef IFID_PERF_CNT_EN
    chk("stall_sat", {30'd0, STALL_CNT}, 32'd3);
`endif
    HOLD  = 1'b0;
    FLUSH = 1'b1;
    offer(1'b1, 32'h24);
    step();
    chk_out("flush", 1'b0, 32'h0, NOP, 1'b1);
`ifdef IFID_PERF_CNT_EN
    chk("flush_cnt", {30'd0, FLUSH_CNT}, 32'd1);
`endif
    FLUSH = 1'b0;
    offer(1'b0, 32'h0);
    step();
    chk_out("post_flush", 1'b0, 32'h0, NOP, 1'b1);

    // async reset in the middle of a cycle while in SKID
    HOLD = 1'b1;
    offer(1'b1, 32'h30);
    step();
    offer(1'b1, 32'h34);
    step();
    chk_out("pre_areset", 1'b1, 32'h30, instr_of(32'h30), 1'b0);
    #2;
    RESET = 1'b1;
    #1;
    chk_out("areset", 1'b0, 32'h0, NOP, 1'b1);
`ifdef IFID_PERF_CNT_EN
    chk("areset.stall_cnt", {30'd0, STALL_CNT}, 32'd0);
`endif
    #1;
    RESET = 1'b0;
    HOLD  = 1'b0;
    offer(1'b0, 32'h0);
    step();
    chk_out("after_areset", 1'b0, 32'h0, NOP, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
